// File: rtl/pass_entry_unit.sv
// ---------------------------------------------------------------------------
// pass_entry_unit
//
// Front end of the smart-home door lock. Shifts a password in bit-serially
// from the keypad, presents it on pass[] to an external combinational
// comparator for exactly one CHECK cycle, and samples the comparator's
// equal result in that cycle. A correct entry produces a one-cycle granted
// pulse. A wrong or short entry bumps the consecutive-failure count. When
// that count reaches MAX_FAIL, the keypad is locked out for LOCK_CYCLES
// cycles.
//
// Optional feature (compile-time macro ENTRY_TIMEOUT_EN):
//   When the macro is defined, an entry that sits in COLLECT for
//   TIMEOUT_CYCLES cycles without a key strobe is discarded. When it is
//   undefined, COLLECT waits indefinitely.
//
// Parameters:
//   PASS_W          password width in bits (>=2)
//   MAX_FAIL        consecutive failures that trigger lockout (1..7)
//   LOCK_CYCLES     lockout duration in clk cycles (>=1)
//   TIMEOUT_CYCLES  idle cycles allowed between key presses (timeout build)
//
// Ports:
//   clk         in   1       system clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   bit_in      in   1       keypad data bit, valid while bit_strobe=1
//   bit_strobe  in   1       one-cycle strobe: shift bit_in into the entry
//   enter       in   1       one-cycle strobe: submit the entry
//   equal       in   1       comparator result for the current pass[]
//   pass        out  PASS_W  entered password, MSB first
//   pass_valid  out  1       high exactly in the CHECK cycle
//   granted     out  1       one-cycle pulse after a successful check
//   locked      out  1       high throughout the lockout
//   fail_cnt    out  3       consecutive-failure count (saturates)
//   state_dbg   out  2       current FSM state (0 IDLE, 1 COLLECT,
//                            2 CHECK, 3 LOCK)
//
// Handshake: bit_strobe and enter are single-cycle valid pulses. There is
// no ready/back-pressure. A strobe is consumed in the cycle it is high or
// is dropped (during CHECK and LOCK, when the entry is already full, or
// when it collides with enter or with a timeout). equal is qualified by
// pass_valid and is ignored in every other cycle.
// ---------------------------------------------------------------------------
module pass_entry_unit #(
  parameter int PASS_W         = 2,
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_strobe,
  input  logic              enter,
  input  logic              equal,
  output logic [PASS_W-1:0] pass,
  output logic              pass_valid,
  output logic              granted,
  output logic              locked,
  output logic [2:0]        fail_cnt,
  output logic [1:0]        state_dbg
);

  // Bit counter must be able to hold the value PASS_W itself ("full").
  localparam int CNT_W = $clog2(PASS_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PASS_W);

  // One timer width serves both the lockout down-counter and, in the
  // timeout build, the idle counter. It is sized for the longer interval.
  localparam int TMR_MAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    LOCK    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             short_entry;  // entry submitted with fewer than PASS_W bits
  logic [TMR_W-1:0] lock_cnt;
  logic [2:0]       fail_next;
  logic             timeout_hit;

  assign state_dbg = state;

  // Failure count after one more failure. It saturates so it can never wrap,
  // even though reaching FAIL_MAX always diverts into LOCK.
  assign fail_next = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 3'd1;

`ifdef ENTRY_TIMEOUT_EN
  // Idle counter: counts COLLECT cycles since the last key strobe.
  logic [TMR_W-1:0] idle_cnt;

  // The timeout cycle is the TIMEOUT_CYCLES-th strobe-free COLLECT cycle.
  // It overrides any strobe or enter arriving in that same cycle.
  assign timeout_hit = (state == COLLECT) && (idle_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != COLLECT || bit_strobe || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TMR_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pass        <= '0;
      bit_cnt     <= '0;
      short_entry <= 1'b0;
      pass_valid  <= 1'b0;
      granted     <= 1'b0;
      locked      <= 1'b0;
      fail_cnt    <= 3'd0;
      lock_cnt    <= '0;
    end else begin
      // pass_valid and granted are single-cycle. They default low and are
      // raised only on the transitions that own them.
      pass_valid <= 1'b0;
      granted    <= 1'b0;

      case (state)
        IDLE: begin
          if (enter) begin
            // Nothing has been keyed in, so this entry is always short.
            // enter wins over a simultaneous strobe.
            state       <= CHECK;
            pass_valid  <= 1'b1;
            short_entry <= 1'b1;
          end else if (bit_strobe) begin
            pass    <= {pass[PASS_W-2:0], bit_in};
            bit_cnt <= CNT_W'(1);
            state   <= COLLECT;
          end
        end

        COLLECT: begin
          if (timeout_hit) begin
            // Abandoned entry: discard it silently without counting a failure.
            pass    <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (enter) begin
            state       <= CHECK;
            pass_valid  <= 1'b1;
            short_entry <= (bit_cnt != CNT_FULL);
          end else if (bit_strobe && (bit_cnt != CNT_FULL)) begin
            // Once the entry is full, extra strobes leave pass and count unchanged.
            pass    <= {pass[PASS_W-2:0], bit_in};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        CHECK: begin
          // equal reflects the pass[] presented during this cycle.
          pass        <= '0;
          bit_cnt     <= '0;
          short_entry <= 1'b0;
          if (equal && !short_entry) begin
            granted  <= 1'b1;
            fail_cnt <= 3'd0;
            state    <= IDLE;
          end else begin
            fail_cnt <= fail_next;
            if (fail_next == FAIL_MAX) begin
              state    <= LOCK;
              locked   <= 1'b1;
              lock_cnt <= TMR_W'(LOCK_CYCLES - 1);
            end else begin
              state <= IDLE;
            end
          end
        end

        LOCK: begin
          // locked is high for lock_cnt = LOCK_CYCLES-1 down to 0, which is
          // exactly LOCK_CYCLES cycles. Keypad inputs are not looked at here.
          if (lock_cnt == '0) begin
            locked   <= 1'b0;
            fail_cnt <= 3'd0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - TMR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pass_entry_unit.sv
// ---------------------------------------------------------------------------
// tb_pass_entry_unit
//
// Directed bench for pass_entry_unit (PASS_W=2, MAX_FAIL=3, LOCK_CYCLES=16,
// TIMEOUT_CYCLES=32). A small comparator model drives equal from pass, using
// the system key 2'b10. force_eq pins equal high.
//
// A reference model of the entry (m_pass/m_cnt/m_fail) predicts each
// submission's outcome. The prediction is pushed to exp_q when enter is
// driven and popped when the DUT shows pass_valid and the following result
// cycle.
// ---------------------------------------------------------------------------
module tb_pass_entry_unit;

  localparam int         PW   = 2;
  localparam int         MAXF = 3;
  localparam int         LOCKC = 16;
  localparam logic [1:0] KEY  = 2'b10;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_strobe, enter, equal, force_eq;
  logic [1:0] pass;
  logic       pass_valid, granted, locked;
  logic [2:0] fail_cnt;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  // External comparator against the system key.
  assign equal = force_eq | (pass == KEY);

  pass_entry_unit #(
    .PASS_W(PW), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
    .enter(enter), .equal(equal), .pass(pass), .pass_valid(pass_valid),
    .granted(granted), .locked(locked), .fail_cnt(fail_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         tests  = 0;
  int         failed = 0;
  logic [7:0] exp_q[$];
  logic [1:0] m_pass;
  int         m_cnt;
  logic [2:0] m_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_bit(input logic b);
    bit_in     = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    if (m_cnt < PW) begin
      m_pass = {m_pass[0], b};
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_pass = 2'b00;
    m_cnt  = 0;
    m_fail = 3'd0;
  endtask

  // Submits the entry (optionally with a colliding bit strobe that must be
  // dropped). Checks the CHECK cycle and then the result cycle.
  task automatic press_enter(input string tag, input logic with_strobe, input logic b);
    logic       shrt, succ, lk;
    logic [2:0] nf;
    int         waited;
    shrt = (m_cnt < PW);
    succ = (force_eq || (m_pass == KEY)) && !shrt;
    nf   = succ ? 3'd0 : m_fail + 3'd1;
    lk   = !succ && (nf == 3'(MAXF));
    exp_q.push_back({6'b0, m_pass});
    // result cycle: {pass_valid, granted, locked, fail_cnt}
    exp_q.push_back({2'b00, 1'b0, succ, lk, nf});

    bit_in     = b;
    bit_strobe = with_strobe;
    enter      = 1'b1;
    tick();
    enter      = 1'b0;
    bit_strobe = 1'b0;

    waited = 0;
    while (!pass_valid && waited < 4) begin
      tick();
      waited++;
    end
    check({tag, "_latency"}, waited, 0);
    check({tag, "_pass_valid"}, pass_valid, 1);
    check({tag, "_pass"}, pass, exp_q.pop_front());
    tick();
    check({tag, "_result"}, {pass_valid, granted, locked, fail_cnt}, exp_q.pop_front());

    m_pass = 2'b00;
    m_cnt  = 0;
    m_fail = lk ? 3'd0 : nf;  // a lockout always ends with the count cleared
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lk_cycles;
    logic pv_seen;

    rst = 1'b1; bit_in = 1'b0; bit_strobe = 1'b0; enter = 1'b0; force_eq = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", {pass, pass_valid, granted, locked, fail_cnt}, 0);
    check("reset_state", state_dbg, 0);
    rst = 1'b0;
    tick();

    // 1: correct key 1,0 -> grant
    strobe_bit(1'b1);
    strobe_bit(1'b0);
    check("t1_collect_pass", pass, 2'b10);
    press_enter("t1_grant", 1'b0, 1'b0);
    tick();
    check("t1_grant_pulse_end", {granted, state_dbg}, 0);

    // 2: three wrong entries -> lockout for exactly LOCKC cycles
    for (int i = 0; i < 3; i++) begin
      strobe_bit(1'b0);
      strobe_bit(1'b1);
      press_enter("t2_wrong", 1'b0, 1'b0);
    end
    lk_cycles = 1;  // first locked cycle already seen in the result check
    pv_seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      enter      = (i == 3) || (i == 9);
      bit_strobe = (i == 5);
      bit_in     = 1'b1;
      tick();
      enter      = 1'b0;
      bit_strobe = 1'b0;
      if (locked) lk_cycles++;
      if (pass_valid) pv_seen = 1'b1;
    end
    check("t2_lock_len", lk_cycles, LOCKC);
    check("t2_no_check_in_lock", pv_seen, 0);
    check("t2_after_lock", {pass, locked, fail_cnt, state_dbg}, 0);

    // 3: short entry with equal forced high -> failure
    force_eq = 1'b1;
    strobe_bit(1'b1);
    press_enter("t3_short", 1'b0, 1'b0);
    force_eq = 1'b0;

    // 4: extra strobe ignored, strobe+enter collision, empty enter
    strobe_bit(1'b1);
    strobe_bit(1'b0);
    strobe_bit(1'b1);
    check("t4_pass_held", pass, 2'b10);
    press_enter("t4_three_strobes", 1'b0, 1'b0);
    strobe_bit(1'b1);
    press_enter("t4_same_cycle", 1'b1, 1'b0);
    press_enter("t4_idle_enter", 1'b0, 1'b0);
    strobe_bit(1'b1);
    strobe_bit(1'b0);
    press_enter("t4_recover", 1'b0, 1'b0);

    // 5a: async reset mid-COLLECT, with a nonzero failure count
    strobe_bit(1'b0);
    strobe_bit(1'b1);
    press_enter("t5_prefail", 1'b0, 1'b0);
    strobe_bit(1'b1);
    check("t5_pre_rst_pass", pass, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("t5_collect_rst_out", {pass, pass_valid, granted, locked, fail_cnt}, 0);
    check("t5_collect_rst_state", state_dbg, 0);
    #1 rst = 1'b0;
    model_reset();
    tick();

    // 5b: async reset mid-LOCK
    for (int i = 0; i < 3; i++) begin
      strobe_bit(1'b1);
      strobe_bit(1'b1);
      press_enter("t5_wrong", 1'b0, 1'b0);
    end
    tick();
    tick();
    check("t5_pre_rst_locked", locked, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_lock_rst_out", {pass, pass_valid, granted, locked, fail_cnt}, 0);
    check("t5_lock_rst_state", state_dbg, 0);
    #1 rst = 1'b0;
    model_reset();
    tick();
    strobe_bit(1'b1);
    strobe_bit(1'b0);
    press_enter("t5_clean", 1'b0, 1'b0);

    // 6: idle behaviour in COLLECT
    strobe_bit(1'b0);
    strobe_bit(1'b1);
    press_enter("t6_prefail", 1'b0, 1'b0);
    strobe_bit(1'b1);
`ifdef ENTRY_TIMEOUT_EN
    repeat (31) tick();
    check("t6_before_timeout", {pass, state_dbg}, {2'b01, 2'd1});
    tick();
    check("t6_timeout_pass", pass, 0);
    check("t6_timeout_state", state_dbg, 0);
    check("t6_timeout_fail", fail_cnt, m_fail);
    m_pass = 2'b00;
    m_cnt  = 0;
`else
    repeat (100) tick();
    check("t6_held_pass", pass, 2'b01);
    check("t6_held_state", state_dbg, 1);
    check("t6_held_fail", fail_cnt, m_fail);
    press_enter("t6_final", 1'b0, 1'b0);
`endif

    check("end_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
